regbank_write_arbiter: RTL and testbench

- Shares the single write port of the register bank between NB_REQ writeback requesters, for example the ALU and load writeback paths.
- Each requester has its own valid/ready handshake. One request is granted per cycle, using round-robin arbitration.
- The granted write is registered and presented to the bank's write_enable_i, rd_add_i and rd_data_i one cycle later.
- Sits between the writeback sources and the register bank.

---
 rtl/regbank_write_arbiter_pkg.sv | 19 +
 rtl/regbank_write_arbiter_if.sv | 32 +++
 rtl/regbank_write_arbiter_rr_arbiter.sv | 40 ++++
 rtl/regbank_write_arbiter.sv | 93 +++++++++
 tb/tb_regbank_write_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/regbank_write_arbiter_pkg.sv
// Shared constants and writeback bundle for the register-bank write arbiter.
package regbank_arb_pkg;

  localparam int NB_REQ_MAX = 8;
  localparam int WB_ADDR_W  = 5;
  localparam int WB_DATA_W  = 32;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO_ADDR = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd_add;
    logic [WB_DATA_W-1:0] rd_data;
  } wb_req_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester handshakes plus the bank write port of the arbiter.
interface regbank_write_arbiter_if
  import regbank_arb_pkg::*;
#(
  parameter int NB_REQ          = 2,
  parameter int nb_bits         = 32,
  parameter int nb_bits_address = 5
);
  localparam int IDW = id_w(NB_REQ);

  logic [NB_REQ-1:0]                      req_valid_i;
  logic [NB_REQ-1:0]                      req_ready_o;
  logic [NB_REQ-1:0][nb_bits_address-1:0] req_rd_add_i;
  logic [NB_REQ-1:0][nb_bits-1:0]         req_rd_data_i;
  logic                                   write_enable_o;
  logic [nb_bits_address-1:0]             rd_add_o;
  logic [nb_bits-1:0]                     rd_data_o;
  logic [IDW-1:0]                         grant_id_o;

  modport master (
    output req_valid_i, req_rd_add_i, req_rd_data_i,
    input  req_ready_o, write_enable_o, rd_add_o,
    input  rd_data_o, grant_id_o
  );

  modport slave (
    input  req_valid_i, req_rd_add_i, req_rd_data_i,
    output req_ready_o, write_enable_o, rd_add_o,
    output rd_data_o, grant_id_o
  );

endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// One-hot grant and next pointer; REGBANK_ARB_FIXED_PRIO_EN selects
// lowest-index-wins instead of round-robin.
module rr_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int NB_REQ = 2,
  parameter int IDW    = id_w(NB_REQ)
) (
  input  logic [NB_REQ-1:0] i_valid,
  input  logic              i_en,
  input  logic [IDW-1:0]    i_ptr,
  output logic [NB_REQ-1:0] o_gnt,
  output logic [IDW-1:0]    o_gnt_id,
  output logic              o_any,
  output logic [IDW-1:0]    o_next_ptr
);

  always_comb begin
    int idx;
    o_gnt      = '0;
    o_gnt_id   = '0;
    o_any      = 1'b0;
    o_next_ptr = i_ptr;
    idx        = 0;
    for (int i = 0; i < NB_REQ; i++) begin
`ifdef REGBANK_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = (int'(i_ptr) + i) % NB_REQ;
`endif
      if (!o_any && i_en && i_valid[idx]) begin
        o_any      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_gnt_id   = IDW'(idx);
        o_next_ptr = IDW'((idx + 1) % NB_REQ);
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register-bank write port between NB_REQ writeback sources.
// Optional macro: REGBANK_ARB_FIXED_PRIO_EN (fixed priority, no rr_ptr).
module regbank_write_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int NB_REQ          = 2,
  parameter int nb_bits         = 32,
  parameter int nb_bits_address = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  regbank_write_arbiter_if.slave  bus
);

  localparam int IDW = id_w(NB_REQ);

  if (NB_REQ < 2 || NB_REQ > NB_REQ_MAX) begin : g_bad_nb_req
    $error("NB_REQ out of range");
  end

  logic [NB_REQ-1:0] w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_any;
  logic [IDW-1:0]    w_ptr;
  logic [IDW-1:0]    w_next_ptr;
  logic              w_en;
  wb_req_t           w_sel;

  logic              r_we;
  wb_req_t           r_wb;
  logic [IDW-1:0]    r_gid;

  // Reset and flush both gate grants so ready never leaks out.
  assign w_en = rst_i & ~flush_i;

  rr_arbiter #(
    .NB_REQ (NB_REQ),
    .IDW    (IDW)
  ) u_arb (
    .i_valid    (bus.req_valid_i),
    .i_en       (w_en),
    .i_ptr      (w_ptr),
    .o_gnt      (w_gnt),
    .o_gnt_id   (w_gnt_id),
    .o_any      (w_any),
    .o_next_ptr (w_next_ptr)
  );

`ifdef REGBANK_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDW-1:0] r_rr_ptr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  assign w_ptr = r_rr_ptr;
`endif

  always_comb begin
    w_sel         = '0;
    w_sel.rd_add  = WB_ADDR_W'(bus.req_rd_add_i[w_gnt_id]);
    w_sel.rd_data = WB_DATA_W'(bus.req_rd_data_i[w_gnt_id]);
  end

  // x0 writes are accepted and registered but never enabled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we  <= 1'b0;
      r_wb  <= '0;
      r_gid <= '0;
    end else if (w_any) begin
      r_we  <= (w_sel.rd_add != REG_ZERO_ADDR);
      r_wb  <= w_sel;
      r_gid <= w_gnt_id;
    end else begin
      r_we  <= 1'b0;
    end
  end

  assign bus.req_ready_o    = w_gnt;
  assign bus.write_enable_o = r_we;
  assign bus.rd_add_o       = nb_bits_address'(r_wb.rd_add);
  assign bus.rd_data_o      = nb_bits'(r_wb.rd_data);
  assign bus.grant_id_o     = r_gid;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter with a register-bank model.
module tb_regbank_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  logic [31:0] bank [32];

  regbank_write_arbiter_if #(
    .NB_REQ(2), .nb_bits(32), .nb_bits_address(5)
  ) bus ();

  regbank_write_arbiter #(
    .NB_REQ(2), .nb_bits(32), .nb_bits_address(5)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.write_enable_o && bus.rd_add_o != 5'd0)
      bank[bus.rd_add_o] <= bus.rd_data_o;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    bus.req_valid_i      = v;
    bus.req_rd_add_i[0]  = a0;
    bus.req_rd_data_i[0] = d0;
    bus.req_rd_add_i[1]  = a1;
    bus.req_rd_data_i[1] = d1;
  endtask

  initial begin
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_add [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_add = '{5'd1, 5'd2, 5'd1, 5'd2};
    for (int i = 0; i < 32; i++) bank[i] = '0;
    drive(2'b01, 5'd0, 32'h0, 5'd0, 32'h0);

    // reset state
    #12;
    chk("rst_we",    64'(bus.write_enable_o), 64'd0);
    chk("rst_add",   64'(bus.rd_add_o),       64'd0);
    chk("rst_data",  64'(bus.rd_data_o),      64'd0);
    chk("rst_gid",   64'(bus.grant_id_o),     64'd0);
    chk("rst_ready", 64'(bus.req_ready_o),    64'd0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();

    // single requester
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    #1;
    chk("single_ready", 64'(bus.req_ready_o), 64'b01);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("single_we",   64'(bus.write_enable_o), 64'd1);
    chk("single_add",  64'(bus.rd_add_o),       64'd5);
    chk("single_data", 64'(bus.rd_data_o),      64'hDEADBEEF);
    chk("single_gid",  64'(bus.grant_id_o),     64'd0);
    tick();
    chk("single_bank", 64'(bank[5]),            64'hDEADBEEF);
    chk("idle_we",     64'(bus.write_enable_o), 64'd0);

    // pointer is now 1: realign with a lone req1 write
    drive(2'b10, 5'd0, 32'h0, 5'd3, 32'h33);
    #1;
    chk("align_ready", 64'(bus.req_ready_o), 64'b10);
    tick();

    // both hold valid for 4 cycles
    drive(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready%0d", i), 64'(bus.req_ready_o), 64'(exp_rdy[i]));
      tick();
      chk($sformatf("rr_we%0d", i),  64'(bus.write_enable_o), 64'd1);
      chk($sformatf("rr_add%0d", i), 64'(bus.rd_add_o),       64'(exp_add[i]));
      chk($sformatf("rr_gid%0d", i), 64'(bus.grant_id_o),     64'(i % 2));
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("rr_bank1", 64'(bank[1]), 64'h11);
    chk("rr_bank2", 64'(bank[2]), 64'h22);

    // same destination from both
    drive(2'b11, 5'd7, 32'hA, 5'd7, 32'hB);
    #1;
    chk("same_ready0", 64'(bus.req_ready_o), 64'b01);
    tick();
    drive(2'b10, 5'd7, 32'hA, 5'd7, 32'hB);
    chk("same_data0", 64'(bus.rd_data_o), 64'hA);
    #1;
    chk("same_ready1", 64'(bus.req_ready_o), 64'b10);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("same_bankA", 64'(bank[7]),        64'hA);
    chk("same_data1", 64'(bus.rd_data_o),  64'hB);
    tick();
    chk("same_bankB", 64'(bank[7]), 64'hB);

    // x0 write
    drive(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0);
    #1;
    chk("x0_ready", 64'(bus.req_ready_o), 64'b01);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("x0_we",   64'(bus.write_enable_o), 64'd0);
    chk("x0_data", 64'(bus.rd_data_o),      64'hFFFF);
    tick();
    chk("x0_bank", 64'(bank[0]), 64'd0);

    // flush with req1 valid
    drive(2'b10, 5'd0, 32'h0, 5'd4, 32'h44);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.req_ready_o), 64'b00);
    tick();
    flush = 1'b0;
    chk("flush_we",   64'(bus.write_enable_o), 64'd0);
    chk("flush_hold", 64'(bus.rd_data_o),      64'hFFFF);
    #1;
    chk("post_flush_ready", 64'(bus.req_ready_o), 64'b10);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("post_flush_we",  64'(bus.write_enable_o), 64'd1);
    chk("post_flush_gid", 64'(bus.grant_id_o),     64'd1);
    tick();
    chk("post_flush_bank", 64'(bank[4]), 64'h44);

    // reset mid-stream; pointer is 1 after the req0 grant below
    drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("pre_rst_we", 64'(bus.write_enable_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_we", 64'(bus.write_enable_o), 64'd0);
    tick();
    chk("rst_drop_bank", 64'(bank[9]), 64'd0);
    #2;
    rst = 1'b1;
    tick();
    drive(2'b11, 5'd10, 32'hAA, 5'd11, 32'hBB);
    #1;
    chk("rst_ptr_ready", 64'(bus.req_ready_o), 64'b01);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("rst_ptr_add", 64'(bus.rd_add_o), 64'd10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
